// File: rtl/dl_lab_pkg.sv
// Shared definitions for the serial subtractor controller.
// DEFAULT_WIDTH : default operand width in bits
// state_e       : controller state encoding
package dl_lab_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor: d = a - b - bin, bout set when the subtraction borrows.
// Two half-subtract stages, with their borrows ORed together.
// Ports:
//   a    in  minuend bit
//   b    in  subtrahend bit
//   bin  in  borrow in
//   d    out difference bit
//   bout out borrow out
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic hs1_d;
    logic hs1_b;
    logic hs2_b;

    // first stage: a - b
    assign hs1_d = a ^ b;
    assign hs1_b = ~a & b;

    // second stage: (a - b) - bin
    assign d     = hs1_d ^ bin;
    assign hs2_b = ~hs1_d & bin;

    assign bout  = hs1_b | hs2_b;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor, LSB first, one bit per clock.
// A start accepted in IDLE loads the operands. SHIFT then runs for WIDTH cycles.
// FINISH publishes diff/borrow_out with a one-cycle done pulse.
//
// state  | meaning
// IDLE   | waiting for start; results hold
// SHIFT  | one difference bit per cycle, counter 0..WIDTH-1
// FINISH | load result registers, pulse done, back to IDLE
//
// Ports:
//   clk        in  clock, rising edge
//   rst_n      in  synchronous active-low reset
//   start      in  operation request, honoured only in IDLE
//   a, b       in  minuend / subtrahend, captured on the accepting edge
//   busy       out high while in SHIFT
//   done       out one-cycle pulse when diff/borrow_out are updated
//   diff       out registered (a - b) mod 2^WIDTH
//   borrow_out out registered final borrow (a < b)
module serial_sub_ctrl
    import dl_lab_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;

    logic             cell_d;
    logic             cell_bout;

    full_sub_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        cnt_d        = cnt_q;
        borrow_d     = borrow_q;
        done_d       = 1'b0;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    res_d    = '0;
                    cnt_d    = '0;
                    borrow_d = 1'b0;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // new bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB
                res_d    = {cell_d, res_q[WIDTH-1:1]};
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                borrow_d = cell_bout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                diff_d       = res_q;
                borrow_out_d = borrow_q;
                done_d       = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            cnt_q        <= '0;
            borrow_q     <= 1'b0;
            done_q       <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            cnt_q        <= cnt_d;
            borrow_q     <= borrow_d;
            done_q       <= done_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
        end
    end

    assign busy       = (state_q == ST_SHIFT);
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8).
module tb_serial_sub_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int n_chk = 0;
    int n_fail = 0;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic modulo 2^W
    function automatic logic [31:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        int xi, yi;
        xi = int'(x);
        yi = int'(y);
        return 32'((xi - yi + (1 << W)) % (1 << W));
    endfunction

    function automatic logic [31:0] ref_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
        return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow_out), 32'd0);
        rst_n = 1'b1;
    endtask

    // Called #1 after an edge with the DUT idle.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        int n;
        int busy_n;
        bit got;
        start = 1'b1;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        busy_n = busy ? 1 : 0;
        n = 0;
        got = 1'b0;
        while (n < 30 && !got) begin
            @(posedge clk);
            n++;
            #1;
            a = W'($urandom);
            b = W'($urandom);
            if (done) got = 1'b1;
            else if (busy) busy_n++;
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, 32'(n), 32'(W + 1));
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(W));
        chk({tag, "_diff"}, 32'(diff), ref_diff(x, y));
        chk({tag, "_borrow"}, 32'(borrow_out), ref_borrow(x, y));
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
    } pair_t;

    initial begin
        pair_t        q[$];
        pair_t        p;
        int           m_left;
        int           got;
        int           cyc;
        int           n;
        bit           exp_done;
        bit           seen;
        logic [W-1:0] prev_diff;
        logic         prev_borrow;

        do_reset();

        // first start on the first edge after reset release
        run_op(8'd100, 8'd37, "op_100_37");
        run_op(8'd5, 8'd9, "op_5_9");
        run_op(8'hFF, 8'hFF, "op_ff_ff");
        run_op(8'h00, 8'hFF, "op_00_ff");
        for (int i = 0; i < 6; i++) begin
            run_op(W'($urandom), W'($urandom), "op_rand");
        end

        // Start re-pulsed mid-SHIFT must be ignored; results hold until FINISH
        prev_diff   = diff;
        prev_borrow = borrow_out;
        start = 1'b1;
        a = 8'd200;
        b = 8'd50;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        seen = 1'b0;
        while (n < 30 && !seen) begin
            if (n == 3) begin
                start = 1'b1;
                a = 8'd7;
                b = 8'd99;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            n++;
            #1;
            if (done) begin
                seen = 1'b1;
            end else begin
                chk("ign_diff_hold", 32'(diff), 32'(prev_diff));
                chk("ign_borrow_hold", 32'(borrow_out), 32'(prev_borrow));
            end
        end
        start = 1'b0;
        chk("ign_done_seen", 32'(seen), 32'd1);
        chk("ign_latency", 32'(n), 32'(W + 1));
        chk("ign_diff", 32'(diff), ref_diff(8'd200, 8'd50));
        chk("ign_borrow", 32'(borrow_out), ref_borrow(8'd200, 8'd50));
        repeat (2) @(posedge clk);
        #1;
        chk("ign_no_queue", 32'(busy), 32'd0);

        // Reset at SHIFT bit 4 aborts the operation
        start = 1'b1;
        a = 8'd77;
        b = 8'd11;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_borrow", 32'(borrow_out), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        run_op(8'd42, 8'd200, "op_after_abort");

        // Random run, start held high: model accepts whenever its own
        // operation timer has expired, and expects done exactly W+1 edges later.
        do_reset();
        start = 1'b1;
        m_left = 0;
        got = 0;
        cyc = 0;
        while (got < 1000 && cyc < 10100) begin
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk);
            cyc++;
            exp_done = 1'b0;
            if (m_left == 0) begin
                p.x = a;
                p.y = b;
                q.push_back(p);
                m_left = W + 1;
            end else begin
                m_left--;
                if (m_left == 0) exp_done = 1'b1;
            end
            #1;
            chk("rnd_done", 32'(done), 32'(exp_done));
            if (done && q.size() > 0) begin
                p = q.pop_front();
                chk("rnd_diff", 32'(diff), ref_diff(p.x, p.y));
                chk("rnd_borrow", 32'(borrow_out), ref_borrow(p.x, p.y));
                got++;
            end
        end
        start = 1'b0;
        chk("rnd_count", 32'(got), 32'd1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001: Parameter WIDTH SHALL be declared with default 8; it is the operand width in bits, legal range 2..32.
REQ-002: clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003: rst_n  input  1  is the reset, synchronous and active-low, sampled on rising clk.
REQ-004: start  input  1  is the operation request, sampled only in IDLE.
REQ-005: a  input  WIDTH  is the minuend, captured on the accepted start.
REQ-006: b  input  WIDTH  is the subtrahend, captured on the accepted start.
REQ-007: busy  output  1  SHALL be high while an operation is in progress (state SHIFT).
REQ-008: done  output  1  SHALL be a one-cycle pulse marking valid results.
REQ-009: diff  output  WIDTH  SHALL be the registered result, equal to (a - b) mod 2^WIDTH.
REQ-010: borrow_out  output  1  SHALL be the registered final borrow, 1 iff a < b (unsigned).

Function
REQ-011: The block SHALL compute the difference bit-serially, LSB first, one bit per clk, using one 1-bit full-subtract cell and a borrow flip-flop.
REQ-012: The FSM SHALL have states IDLE, SHIFT and FINISH; no other state is reachable.
REQ-013: In IDLE with start=1, the block SHALL capture a and b into shift registers, clear the borrow flop and the bit counter, and enter SHIFT.
REQ-014: In SHIFT, each cycle SHALL compute d = a0 ^ b0 ^ bin and bout = (~a0 & b0) | (~(a0 ^ b0) & bin), shift d into the result MSB, shift the operand registers right, and register bout.
REQ-015: The bit counter SHALL count 0..WIDTH-1; in SHIFT with count = WIDTH-1, the block SHALL enter FINISH.
REQ-016: In FINISH, the block SHALL load diff and borrow_out from the internal result and borrow, assert done for exactly that cycle, and return to IDLE.
REQ-017: Latency SHALL be WIDTH+1 cycles from the edge that accepts start to the edge that asserts done; throughput SHALL be one operation per WIDTH+2 cycles.
REQ-018: start while busy or in FINISH SHALL be ignored; no queuing is performed.
REQ-019: a and b SHALL be don't-care except on the accepting edge; later changes SHALL NOT affect the result.
REQ-020: diff and borrow_out SHALL hold their values until the next FINISH; they SHALL NOT change during SHIFT.
REQ-021: start held high continuously SHALL start a new operation on the first IDLE cycle after FINISH.
REQ-022: The case a = b SHALL give diff=0 and borrow_out=0; the case a=0, b=2^WIDTH-1 SHALL give diff=1 and borrow_out=1.

Reset
REQ-023: With rst_n=0 at a rising edge, the state SHALL become IDLE and busy, done, diff, borrow_out, the counter, the borrow flop and the shift registers SHALL all become 0.
REQ-024: A reset asserted during SHIFT or FINISH SHALL abort the operation without a done pulse; start SHALL be ignored while rst_n=0.
REQ-025: The first start can be accepted on the first edge with rst_n=1.

Structure
REQ-026: The state encodings (IDLE=2'd0, SHIFT=2'd1, FINISH=2'd2) and the default WIDTH SHALL live in the shared lab package/include dl_lab_pkg.
REQ-027: The 1-bit full-subtract cell SHALL be a separate sub-module, full_sub_cell, built from two half-subtract stages plus an OR on their borrows.
REQ-028: The controller SHALL be purely synchronous, with no latches and no combinational path from inputs to outputs.

Verification (WIDTH=8)
REQ-029: Reset, then start with a=8'd100, b=8'd37 -> done pulses 9 cycles later with diff=8'd63 and borrow_out=0; busy high for 8 cycles.
REQ-030: a=8'd5, b=8'd9 -> diff=8'd252 and borrow_out=1.
REQ-031: a=8'hFF, b=8'hFF, then a=8'h00, b=8'hFF -> diff=0/borrow_out=0, then diff=8'h01/borrow_out=1.
REQ-032: Pulse start again with different operands 3 cycles into SHIFT -> ignored; the original result is reported and diff is unchanged until FINISH.
REQ-033: rst_n=0 for one cycle at SHIFT bit 4 -> no done pulse, all outputs 0 next cycle, and a new start completes correctly.
REQ-034: Random 1000-vector run with start held high -> done every 10 cycles, and each diff/borrow_out matches the reference (a-b) mod 256 and a<b.
